// File: rtl/sram_like_arbiter_n_if.sv
// Sram-like bus bundle: N request lanes with per-lane handshake and read data.
// The arbiter uses N=NCH on its master-facing side and N=1 toward the slave.
interface sram_like_arbiter_n_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int SW = DATA_W / 8;

  logic [N-1:0]        req;
  logic [N-1:0]        wr;
  logic [2*N-1:0]      size;
  logic [SW*N-1:0]     wstrb;
  logic [ADDR_W*N-1:0] addr;
  logic [DATA_W*N-1:0] wdata;
  logic [N-1:0]        addr_ok;
  logic [N-1:0]        data_ok;
  logic [DATA_W*N-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter_n.sv
// N-channel sram-like arbiter with an in-order tag FIFO routing responses back.
// Optional macro SRAM_ARB_CANCEL_EN adds a per-channel cancel that drops queued responses.
module sram_like_arbiter_n #(
  parameter int NCH     = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int ARB_RR  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef SRAM_ARB_CANCEL_EN
  input  logic [NCH-1:0]       cancel,
`endif
  sram_like_arbiter_n_if.slave  m,
  sram_like_arbiter_n_if.master s
);
  localparam int SW    = DATA_W / 8;
  localparam int ID_W  = $clog2(NCH);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(MAX_OUT - 1);
  localparam logic [ID_W-1:0]  ID_END  = ID_W'(NCH - 1);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_e;

  lock_e            lock_q, lock_d;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]  tag_q [MAX_OUT];
  logic [ID_W-1:0]  tag_d [MAX_OUT];
`ifdef SRAM_ARB_CANCEL_EN
  logic [MAX_OUT-1:0] discard_q, discard_d;
`endif

  logic [ID_W-1:0] start, grant, head;
  logic            found, s_req_w, hs, pop, deliver;
  logic [NCH-1:0]  addr_ok_w, data_ok_w;
  int              idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    start = (ARB_RR != 0) ? rr_ptr_q : '0;
    found = 1'b0;
    idx   = 0;
    grant = lock_id_q;
    if (lock_q == ST_OPEN) begin
      grant = '0;
      for (int k = 0; k < NCH; k++) begin
        idx = (int'(start) + k) % NCH;
        if (!found && m.req[idx]) begin
          grant = ID_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign s_req_w = (|m.req) && (count_q < FULL);
  assign hs      = s_req_w && s.addr_ok[0];
  assign pop     = s.data_ok[0] && (count_q != '0);
  assign head    = tag_q[rd_ptr_q];

  always_comb begin
    deliver = pop;
`ifdef SRAM_ARB_CANCEL_EN
    deliver = pop && !discard_q[rd_ptr_q];
`endif
    addr_ok_w = '0;
    data_ok_w = '0;
    if (hs)      addr_ok_w[grant] = 1'b1;
    if (deliver) data_ok_w[head]  = 1'b1;
  end

  // Slave fields follow the grant combinationally; the lock keeps them stable while stalled.
  assign s.req     = s_req_w;
  assign s.wr      = m.wr[grant];
  assign s.size    = m.size[grant*2 +: 2];
  assign s.wstrb   = m.wstrb[grant*SW +: SW];
  assign s.addr    = m.addr[grant*ADDR_W +: ADDR_W];
  assign s.wdata   = m.wdata[grant*DATA_W +: DATA_W];
  assign m.addr_ok = addr_ok_w;
  assign m.data_ok = data_ok_w;
  assign m.rdata   = {NCH{s.rdata}};

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tag_d     = tag_q;
    if (hs) begin
      lock_d          = ST_OPEN;
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = (wr_ptr_q == PTR_END) ? '0 : wr_ptr_q + 1'b1;
      if (ARB_RR != 0) rr_ptr_d = (grant == ID_END) ? '0 : grant + 1'b1;
    end else if (s_req_w) begin
      lock_d    = ST_LOCKED;
      lock_id_d = grant;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_END) ? '0 : rd_ptr_q + 1'b1;
    case ({hs, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef SRAM_ARB_CANCEL_EN
  // Stale slots may be marked too; a push always rewrites its own discard bit.
  always_comb begin
    discard_d = discard_q;
    for (int e = 0; e < MAX_OUT; e++) begin
      if (cancel[tag_q[e]]) discard_d[e] = 1'b1;
    end
    if (hs) discard_d[wr_ptr_q] = cancel[grant];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= ST_OPEN;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; count/pointers alone decide which slots are valid.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
`ifdef SRAM_ARB_CANCEL_EN
    discard_q <= discard_d;
`endif
  end

  a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(s.data_ok[0] && (count_q == '0)));

endmodule
